// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C write master
// Contents:
//   state_t            frame sequencer states
//   Q0..Q3             quarter-bit phase values
//   ADDR_W_DEF/DATA_W_DEF  default address / payload widths
package i2c_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_write_master_qtr_phase.sv
// rtl/i2c_write_master_qtr_phase.sv - tick-enabled quarter-bit phase counter
// Ports:
//   ck       in   system clock
//   reset    in   synchronous active-high reset
//   tick     in   quarter-bit enable, one ck wide
//   run      in   counter advances only while a frame is in flight
//   qtr      out  current quarter (Q0..Q3)
//   q3_tick  out  tick landing on the last quarter of a bit/phase
module i2c_qtr_phase
  import i2c_pkg::*;
(
  input  logic       ck,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  output logic [1:0] qtr,
  output logic       q3_tick
);

  // Held at Q0 while idle so a tick coinciding with accept does not
  // consume the first quarter of START.
  always_ff @(posedge ck) begin
    if (reset) begin
      qtr <= Q0;
    end else if (tick && run) begin
      qtr <= qtr + 2'd1;
    end
  end

  assign q3_tick = tick && run && (qtr == Q3);

endmodule

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - single-byte I2C write master (START, addr+W, ACK, data, ACK, STOP)
// Ports:
//   ck       in   system clock
//   reset    in   synchronous active-high reset
//   tick     in   quarter-bit enable from the divider
//   start    in   transaction request, honoured only in IDLE
//   addr     in   7-bit slave address, latched on accept
//   wdata    in   payload byte, latched on accept
//   sda_in   in   sampled SDA pad level
//   scl      out  SCL level (push-pull)
//   sda_oe   out  1 = pull SDA low
//   busy     out  transaction in flight
//   done     out  one-ck end-of-transaction pulse
//   ack_err  out  NACK seen in the last transaction
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sda_in,
  output logic              scl,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);

  localparam int BC_W = $clog2(DATA_W);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic [DATA_W-1:0] data_r, data_nxt;
  logic [BC_W-1:0]   bitcnt, bitcnt_nxt;
  logic              scl_nxt, sda_oe_nxt, busy_nxt, done_nxt, ack_err_nxt;
  logic [1:0]        qtr;
  logic              q3_tick;

  i2c_qtr_phase u_qtr (
    .ck      (ck),
    .reset   (reset),
    .tick    (tick),
    .run     (state != IDLE),
    .qtr     (qtr),
    .q3_tick (q3_tick)
  );

  always_ff @(posedge ck) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      data_r  <= '0;
      bitcnt  <= '0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      sh      <= sh_nxt;
      data_r  <= data_nxt;
      bitcnt  <= bitcnt_nxt;
      scl     <= scl_nxt;
      sda_oe  <= sda_oe_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      ack_err <= ack_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sh_nxt      = sh;
    data_nxt    = data_r;
    bitcnt_nxt  = bitcnt;
    scl_nxt     = scl;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    ack_err_nxt = ack_err;

    case (state)
      IDLE: begin
        // The done cycle is already IDLE; a request there is dropped.
        if (start && !done) begin
          state_nxt   = START;
          busy_nxt    = 1'b1;
          ack_err_nxt = 1'b0;
          sh_nxt      = DATA_W'({addr, 1'b0});
          data_nxt    = wdata;
        end
      end

      START: begin
        if (tick) begin
          case (qtr)
            Q0, Q1:  begin scl_nxt = 1'b1; sda_oe_nxt = 1'b0; end
            Q2:      sda_oe_nxt = 1'b1;
            default: scl_nxt = 1'b0;
          endcase
        end
        if (q3_tick) begin
          state_nxt  = ADDR;
          bitcnt_nxt = BC_W'(DATA_W - 1);
        end
      end

      ADDR, DATA: begin
        if (tick) begin
          case (qtr)
            Q0:      begin scl_nxt = 1'b0; sda_oe_nxt = ~sh[DATA_W-1]; end
            Q1:      scl_nxt = 1'b1;
            Q2:      ;
            default: scl_nxt = 1'b0;
          endcase
        end
        if (q3_tick) begin
          sh_nxt = {sh[DATA_W-2:0], 1'b0};
          if (bitcnt == '0) begin
            state_nxt = (state == ADDR) ? ACK1 : ACK2;
          end else begin
            bitcnt_nxt = bitcnt - BC_W'(1);
          end
        end
      end

      ACK1, ACK2: begin
        if (tick) begin
          case (qtr)
            Q0:      begin scl_nxt = 1'b0; sda_oe_nxt = 1'b0; end
            Q1:      scl_nxt = 1'b1;
            Q2:      ack_err_nxt = ack_err | sda_in;
            default: scl_nxt = 1'b0;
          endcase
        end
        if (q3_tick) begin
          // ack_err was registered on the Q2 tick, so it reflects this slot.
          if (state == ACK1 && !ack_err) begin
            state_nxt  = DATA;
            sh_nxt     = data_r;
            bitcnt_nxt = BC_W'(DATA_W - 1);
          end else begin
            state_nxt = STOP;
          end
        end
      end

      STOP: begin
        if (tick) begin
          case (qtr)
            Q0:      begin scl_nxt = 1'b0; sda_oe_nxt = 1'b1; end
            Q1:      scl_nxt = 1'b1;
            Q2:      sda_oe_nxt = 1'b0;
            default: ;
          endcase
        end
        if (q3_tick) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - directed self-checking bench for i2c_write_master
module tb_i2c_write_master;

  logic       ck = 1'b0;
  logic       reset;
  logic       tick = 1'b0;
  logic       start;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       sda_in = 1'b1;
  logic       scl, sda_oe, busy, done, ack_err;

  int checks = 0;
  int failures = 0;

  int   phase = 0;
  logic tick_en = 1'b1;

  // slave / bus monitor state
  logic       ack_addr = 1'b1, ack_data = 1'b1;
  logic       slave_low = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bitn = 0, rises = 0, starts = 0, stops = 0;
  logic [7:0] byte0 = 8'h00, byte1 = 8'h00;
  int         hold_changes = 0;
  logic       h_scl, h_sda;
  int         n, busy_cnt;

  i2c_write_master dut (
    .ck      (ck),
    .reset   (reset),
    .tick    (tick),
    .start   (start),
    .addr    (addr),
    .wdata   (wdata),
    .sda_in  (sda_in),
    .scl     (scl),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One ck: drive tick, advance, then run the slave model and bus monitor.
  task automatic cyc();
    logic bus;
    tick = tick_en && (phase == 0);
    @(posedge ck);
    #1;
    phase = (phase + 1) % 4;
    if (prev_scl && !scl) begin
      if (bitn == 8)                     slave_low = ack_addr;
      else if (bitn == 17)               slave_low = ack_data;
      else if (bitn == 9 || bitn == 18)  slave_low = 1'b0;
    end
    bus = !(sda_oe || slave_low);
    sda_in = bus;
    if (prev_scl && scl && (bus != prev_sda)) begin
      if (!bus) begin
        starts++;
        bitn = 0;
      end else begin
        stops++;
      end
    end else if (!prev_scl && scl) begin
      rises++;
      bitn++;
      if (bitn <= 8)                     byte0 = {byte0[6:0], bus};
      else if (bitn >= 10 && bitn <= 17) byte1 = {byte1[6:0], bus};
    end
    prev_scl = scl;
    prev_sda = bus;
  endtask

  task automatic clear_mon();
    bitn = 0; rises = 0; starts = 0; stops = 0;
    byte0 = 8'h00; byte1 = 8'h00; slave_low = 1'b0; hold_changes = 0;
  endtask

  // Accept on an edge that also carries a tick.
  task automatic launch(input logic [6:0] a, input logic [7:0] d);
    while (phase != 0) cyc();
    addr = a; wdata = d; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int hold_at, input int inj_at, output int cnt);
    cnt = 0;
    do begin
      cnt++;
      if (cnt == inj_at)     begin start = 1'b1; addr = 7'h11; wdata = 8'h22; end
      if (cnt == inj_at + 1) start = 1'b0;
      if (hold_at > 0 && cnt == hold_at) begin
        tick_en = 1'b0; h_scl = scl; h_sda = sda_oe;
      end
      if (hold_at > 0 && cnt == hold_at + 100) tick_en = 1'b1;
      cyc();
      if (hold_at > 0 && cnt >= hold_at && cnt < hold_at + 100 &&
          (scl !== h_scl || sda_oe !== h_sda)) hold_changes++;
    end while (!done && cnt < 2000);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; addr = '0; wdata = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);

    // full frame, both bytes ACKed
    ack_addr = 1'b1; ack_data = 1'b1; clear_mon();
    launch(7'h50, 8'hA5);
    chk("t1_busy", busy, 1);
    chk("t1_ack_err_clr", ack_err, 0);
    wait_done(-1, -1, n);
    chk("t1_latency", n, 320);
    chk("t1_addr_byte", byte0, 8'hA0);
    chk("t1_data_byte", byte1, 8'hA5);
    chk("t1_ack_err", ack_err, 0);
    chk("t1_rises", rises, 19);
    chk("t1_starts", starts, 1);
    chk("t1_stops", stops, 1);
    cyc();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);

    // address NACK
    ack_addr = 1'b0; ack_data = 1'b1; clear_mon();
    launch(7'h3C, 8'h5A);
    wait_done(-1, -1, n);
    chk("t2_latency", n, 176);
    chk("t2_ack_err", ack_err, 1);
    chk("t2_addr_byte", byte0, 8'h78);
    chk("t2_rises", rises, 10);
    chk("t2_starts", starts, 1);
    chk("t2_stops", stops, 1);

    // data NACK
    ack_addr = 1'b1; ack_data = 1'b0; clear_mon();
    launch(7'h2A, 8'hC3);
    chk("t3_ack_err_clr", ack_err, 0);
    wait_done(-1, -1, n);
    chk("t3_latency", n, 320);
    chk("t3_ack_err", ack_err, 1);
    chk("t3_data_byte", byte1, 8'hC3);
    chk("t3_stops", stops, 1);
    chk("t3_rises", rises, 19);

    // start pulsed at tick 20 while busy
    ack_addr = 1'b1; ack_data = 1'b1; clear_mon();
    launch(7'h50, 8'hA5);
    wait_done(-1, 80, n);
    chk("t4_latency", n, 320);
    chk("t4_addr_byte", byte0, 8'hA0);
    chk("t4_data_byte", byte1, 8'hA5);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (busy !== 1'b0 || scl !== 1'b1) busy_cnt++;
    end
    chk("t4_no_second_frame", busy_cnt, 0);
    chk("t4_starts", starts, 1);

    // reset at tick 30, mid-address
    clear_mon();
    launch(7'h50, 8'hA5);
    repeat (120) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_scl", scl, 1);
    chk("t5_sda_oe", sda_oe, 0);
    chk("t5_busy", busy, 0);
    cyc(); cyc();
    clear_mon();
    launch(7'h50, 8'hA5);
    chk("t5_reaccept_busy", busy, 1);
    wait_done(-1, -1, n);
    chk("t5_latency", n, 320);
    chk("t5_addr_byte", byte0, 8'hA0);
    chk("t5_data_byte", byte1, 8'hA5);

    // tick held low for 100 ck mid-DATA
    clear_mon();
    launch(7'h50, 8'hA5);
    wait_done(200, -1, n);
    chk("t6_hold_frozen", hold_changes, 0);
    chk("t6_latency", n, 420);
    chk("t6_addr_byte", byte0, 8'hA0);
    chk("t6_data_byte", byte1, 8'hA5);
    chk("t6_starts", starts, 1);
    chk("t6_stops", stops, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
